binary_bbox_extractor: RTL and testbench
========================================

Name: binary_bbox_extractor

Overview:
- Consumer end of the 1-bit binary image stream (vsync/href/clken/Bit) emitted by the morphology stages (erosion/dilation) of the multi-target detection pipeline.
- Tracks pixel position and accumulates the bounding box (xmin/xmax/ymin/ymax) and set-pixel count of all Bit=1 pixels in a frame.
- At end of frame, presents the result with a one-cycle valid pulse for the overlay/tracking logic downstream.

Parameters:
- IMG_HDISP, 10'd640, active pixels per line; column index range 0..IMG_HDISP-1
- IMG_VDISP, 10'd480, active lines per frame; row index range 0..IMG_VDISP-1
- MIN_PIX, 20'd16, minimum set-pixel count for box_found=1

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  reset, synchronous, active-low
- per_frame_vsync  input  1  high for the whole active frame
- per_frame_href  input  1  high for each active line
- per_frame_clken  input  1  pixel-valid strobe, qualified by href
- per_img_Bit  input  1  binary pixel, 1 = object
- box_valid  output  1  one-cycle pulse, result registers updated
- box_found  output  1  1 = pix_cnt >= MIN_PIX in the completed frame
- box_xmin  output  10  leftmost set column
- box_xmax  output  10  rightmost set column
- box_ymin  output  10  top set row
- box_ymax  output  10  bottom set row
- box_pix_cnt  output  20  set pixels in frame, saturating at 20'hFFFFF
- frame_err  output  1  frame had >IMG_HDISP pixels in a line or >IMG_VDISP lines

Behaviour:
- Reset is synchronous: sys_rst_n sampled low at a rising edge clears all state.
  - Outputs after reset: box_valid=0, box_found=0, coordinates=0, box_pix_cnt=0, frame_err=0.
  - FSM goes to IDLE and internal counters clear.
- Edge detection: vsync_r and href_r are registered copies of the inputs.
  - vsync rise = vsync & ~vsync_r; vsync fall = ~vsync & vsync_r; href fall = ~href & href_r.
- FSM states IDLE, ACTIVE, DONE:
  - IDLE -> ACTIVE on vsync rise. On entry, clear hcnt=0, vcnt=0, acc_xmin=IMG_HDISP-1, acc_xmax=0, acc_ymin=IMG_VDISP-1, acc_ymax=0, acc_cnt=0, acc_err=0.
  - ACTIVE -> DONE on vsync fall.
  - DONE -> IDLE unconditionally after 1 cycle.
- In DONE, the output registers load from the accumulators, and box_valid=1 for that cycle only.
  - Net latency: box_valid is high exactly 1 cycle after the first cycle vsync is sampled low.
  - Outputs hold their values until the next DONE.
- Pixel accepted when state==ACTIVE & per_frame_vsync & per_frame_href & per_frame_clken.
  - Accepted and Bit=1 with hcnt<IMG_HDISP and vcnt<IMG_VDISP:
    - acc_xmin = min(acc_xmin, hcnt); acc_xmax = max(acc_xmax, hcnt)
    - acc_ymin = min(acc_ymin, vcnt); acc_ymax = max(acc_ymax, vcnt)
    - acc_cnt += 1, saturating at 20'hFFFFF
  - Every accepted pixel: hcnt increments, saturating at IMG_HDISP. A pixel arriving with hcnt==IMG_HDISP is ignored and sets acc_err.
- Line end: on href fall in ACTIVE, hcnt=0 and vcnt increments, saturating at IMG_VDISP.
  - A pixel accepted with vcnt==IMG_VDISP is ignored and sets acc_err.
- Frame with acc_cnt < MIN_PIX (including 0): box_found=0 and all four coordinates output 0; box_pix_cnt still reports acc_cnt.
- On the vsync-fall cycle vsync is low, so any clken on that cycle is not accepted.
- href fall and vsync fall in the same cycle: vcnt update is irrelevant, DONE proceeds.
- Reset mid-frame: partial frame discarded.
  - After reset the block waits in IDLE for a new vsync rise; vsync still high when reset releases does not start a frame.
  - No box_valid for the aborted frame.
- Gaps in clken within a line are legal and do not advance hcnt.
- Vsync rise in DONE cannot occur (vsync fall just happened); in IDLE it is taken the cycle it occurs.

Decomposition:
- Shared package (morph_pkg):
  - COORD_W=10, CNT_W=20
  - FSM state encoding IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2
  - CNT_SAT=20'hFFFFF
- Sub-module binary_stream_pos_cnt:
  - Performs edge detection and hcnt/vcnt generation with saturation and error flags.
  - Reused by later multi-target labelling blocks.
- The top module holds the FSM, accumulators and output registers.

Test Plan:
- Sim config IMG_HDISP=8, IMG_VDISP=6, MIN_PIX=2; one frame with Bit=1 at (2,1),(5,1),(3,4) -> 1 cycle after vsync fall: box_valid=1 for 1 cycle, found=1, xmin=2, xmax=5, ymin=1, ymax=4, pix_cnt=3, frame_err=0.
- All-zero frame -> box_valid pulse, found=0, coordinates=0, pix_cnt=0; a single set pixel at (7,5) -> found=0, pix_cnt=1.
- Line with 9 clken pulses, the 9th with Bit=1 -> frame_err=1 and the 9th pixel is excluded from box and count; the next clean frame reports frame_err=0.
- Random clken gaps inside lines, pixels at (0,0) and (7,5) -> xmin=0, xmax=7, ymin=0, ymax=5, pix_cnt=2, found=1.
- Assert sys_rst_n low for 1 cycle mid-frame with vsync held high -> all outputs 0, no box_valid at that vsync fall; the next full frame reports correctly.
- Back-to-back frames with 1 idle cycle between vsync fall and rise -> two box_valid pulses; second frame's results independent of the first (accumulators re-initialised).

Source files
------------

// File: rtl/morph_pkg.sv
// Shared types and constants for the binary-image stream stages of the
// multi-target detection pipeline.
package morph_pkg;

    localparam int COORD_W = 10;
    localparam int CNT_W   = 20;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam cnt_t CNT_SAT = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Per-frame bounding-box result, used for both accumulator and output registers.
    typedef struct packed {
        coord_t xmin;
        coord_t xmax;
        coord_t ymin;
        coord_t ymax;
        cnt_t   cnt;
        logic   err;
    } box_t;

endpackage

// File: rtl/binary_bbox_extractor_if.sv
// Binary pixel stream in, per-frame bounding-box result out.
// The stream source is the master; the extractor is the slave.
interface binary_bbox_extractor_if;
    import morph_pkg::*;

    logic   per_frame_vsync;
    logic   per_frame_href;
    logic   per_frame_clken;
    logic   per_img_Bit;

    logic   box_valid;
    logic   box_found;
    coord_t box_xmin;
    coord_t box_xmax;
    coord_t box_ymin;
    coord_t box_ymax;
    cnt_t   box_pix_cnt;
    logic   frame_err;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        input  box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax,
               box_pix_cnt, frame_err
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        output box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax,
               box_pix_cnt, frame_err
    );

endinterface

// File: rtl/binary_stream_pos_cnt.sv
// Sync edge detection and saturating column/row position for a binary
// pixel stream; flags pixels that fall outside the active window.
module binary_stream_pos_cnt
    import morph_pkg::*;
#(
    parameter coord_t HDISP = 10'd640,
    parameter coord_t VDISP = 10'd480
) (
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    input  logic   vsync_i,
    input  logic   href_i,
    input  logic   clken_i,
    input  logic   clear_i,
    input  logic   active_i,
    output coord_t hcnt_o,
    output coord_t vcnt_o,
    output logic   vsync_rise_o,
    output logic   vsync_fall_o,
    output logic   pix_ok_o,
    output logic   pix_err_o
);

    logic   vsync_q, href_q;
    logic   href_fall, pix_acc, h_full, v_full;
    coord_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;

    assign vsync_rise_o = vsync_i & ~vsync_q;
    assign vsync_fall_o = ~vsync_i & vsync_q;
    assign href_fall    = ~href_i & href_q;

    assign pix_acc   = active_i & vsync_i & href_i & clken_i;
    assign h_full    = (hcnt_q == HDISP);
    assign v_full    = (vcnt_q == VDISP);
    assign pix_ok_o  = pix_acc & ~h_full & ~v_full;
    assign pix_err_o = pix_acc & (h_full | v_full);

    assign hcnt_o = hcnt_q;
    assign vcnt_o = vcnt_q;

    always_comb begin
        // NOTE: defaults first so every path assigns both counters; no latches.
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (clear_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (active_i) begin
            if (href_fall) begin
                hcnt_d = '0;
                if (!v_full) vcnt_d = vcnt_q + coord_t'(1);
            end else if (pix_acc && !h_full) begin
                hcnt_d = hcnt_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            // NOTE: vsync history resets high so a vsync already high at reset
            // release is not mistaken for the start of a frame.
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

endmodule

// File: rtl/binary_bbox_extractor.sv
// Accumulates the bounding box and set-pixel count of a binary frame and
// publishes the result with a one-cycle valid pulse after vsync falls.
module binary_bbox_extractor
    import morph_pkg::*;
#(
    parameter coord_t IMG_HDISP = 10'd640,
    parameter coord_t IMG_VDISP = 10'd480,
    parameter cnt_t   MIN_PIX   = 20'd16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    binary_bbox_extractor_if.slave  img_if
);

    state_t state_q;
    box_t   acc_q, acc_d, out_q;
    logic   valid_q, found_q;

    logic   vsync_rise, vsync_fall, pix_ok, pix_err;
    coord_t hcnt, vcnt;

    binary_stream_pos_cnt #(
        .HDISP (IMG_HDISP),
        .VDISP (IMG_VDISP)
    ) u_pos_cnt (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .vsync_i      (img_if.per_frame_vsync),
        .href_i       (img_if.per_frame_href),
        .clken_i      (img_if.per_frame_clken),
        .clear_i      ((state_q == IDLE) && vsync_rise),
        .active_i     (state_q == ACTIVE),
        .hcnt_o       (hcnt),
        .vcnt_o       (vcnt),
        .vsync_rise_o (vsync_rise),
        .vsync_fall_o (vsync_fall),
        .pix_ok_o     (pix_ok),
        .pix_err_o    (pix_err)
    );

    always_comb begin
        acc_d = acc_q;
        if (state_q == IDLE && vsync_rise) begin
            acc_d = '{xmin: IMG_HDISP - coord_t'(1), xmax: '0,
                      ymin: IMG_VDISP - coord_t'(1), ymax: '0,
                      cnt: '0, err: 1'b0};
        end else if (state_q == ACTIVE) begin
            if (pix_err) acc_d.err = 1'b1;
            if (pix_ok && img_if.per_img_Bit) begin
                if (hcnt < acc_q.xmin) acc_d.xmin = hcnt;
                if (hcnt > acc_q.xmax) acc_d.xmax = hcnt;
                if (vcnt < acc_q.ymin) acc_d.ymin = vcnt;
                if (vcnt > acc_q.ymax) acc_d.ymax = vcnt;
                if (acc_q.cnt != CNT_SAT) acc_d.cnt = acc_q.cnt + cnt_t'(1);
            end
        end
    end

    // Results load on the vsync-fall edge so they are visible during DONE.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            found_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vsync_rise) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (vsync_fall) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        found_q <= (acc_q.cnt >= MIN_PIX);
                        out_q   <= (acc_q.cnt >= MIN_PIX) ? acc_q :
                                   '{xmin: '0, xmax: '0, ymin: '0, ymax: '0,
                                     cnt: acc_q.cnt, err: acc_q.err};
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign img_if.box_valid   = valid_q;
    assign img_if.box_found   = found_q;
    assign img_if.box_xmin    = out_q.xmin;
    assign img_if.box_xmax    = out_q.xmax;
    assign img_if.box_ymin    = out_q.ymin;
    assign img_if.box_ymax    = out_q.ymax;
    assign img_if.box_pix_cnt = out_q.cnt;
    assign img_if.frame_err   = out_q.err;

endmodule

// File: tb/tb_binary_bbox_extractor.sv
// Directed bench for binary_bbox_extractor on an 8x6 image with MIN_PIX=2.
module tb_binary_bbox_extractor;

    typedef logic [62:0] res_t;
    typedef logic [7:0]  img_t [6];

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    binary_bbox_extractor_if bif ();

    binary_bbox_extractor #(
        .IMG_HDISP (10'd8),
        .IMG_VDISP (10'd6),
        .MIN_PIX   (20'd2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .img_if    (bif.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected snapshot: {valid, found, xmin, xmax, ymin, ymax, pix_cnt, err}
    function automatic res_t ev(input bit v, input bit f, input int x0, input int x1,
                                input int y0, input int y1, input int c, input bit e);
        return {v, f, 10'(x0), 10'(x1), 10'(y0), 10'(y1), 20'(c), e};
    endfunction

    function automatic res_t got();
        return {bif.box_valid, bif.box_found, bif.box_xmin, bif.box_xmax,
                bif.box_ymin, bif.box_ymax, bif.box_pix_cnt, bif.frame_err};
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("valid=%0d found=%0d x=%0d..%0d y=%0d..%0d cnt=%0d err=%0d",
                         r[62], r[61], r[60:51], r[50:41], r[40:31], r[30:21], r[20:1], r[0]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_line(input int npix, input logic [15:0] bits, input bit gaps);
        bif.per_frame_href = 1'b1;
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                bif.per_frame_clken = 1'b0;
                bif.per_img_Bit     = 1'b1;
                cyc($urandom_range(0, 2));
            end
            bif.per_frame_clken = 1'b1;
            bif.per_img_Bit     = bits[i];
            cyc(1);
        end
        bif.per_frame_clken = 1'b0;
        bif.per_img_Bit     = 1'b0;
        bif.per_frame_href  = 1'b0;
        cyc(2);
    endtask

    task automatic send_image(input img_t img, input bit gaps);
        bif.per_frame_vsync = 1'b1;
        cyc(2);
        for (int r = 0; r < 6; r++) send_line(8, {8'h00, img[r]}, gaps);
    endtask

    task automatic test_reset();
        res_t r;
        int   pulses = 0;
        sys_rst_n = 1'b0;
        bif.per_frame_vsync = 1'b1;
        cyc(3);
        sys_rst_n = 1'b1;
        cyc(1);
        r = got();
        tests_run++;
        if (r !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got %s required all zero", fmt(r));
        end
        // vsync high across reset release must not open a frame
        send_line(8, 16'h00FF, 1'b0);
        bif.per_frame_vsync = 1'b0;
        repeat (4) begin
            cyc(1);
            if (bif.box_valid) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL no_frame_after_reset: got %0d valid pulses required 0", pulses);
        end
    endtask

    task automatic test_basic();
        img_t im = '{default: 8'h00};
        res_t r, e;
        im[1] = 8'h24;
        im[4] = 8'h08;
        send_image(im, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 2, 5, 1, 4, 3, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL basic_result: got %s required %s", fmt(r), fmt(e));
        end
        cyc(1);
        r = got(); e = ev(0, 1, 2, 5, 1, 4, 3, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL basic_pulse_hold: got %s required %s", fmt(r), fmt(e));
        end
        cyc(2);
    endtask

    task automatic test_small_frames();
        img_t im = '{default: 8'h00};
        res_t r, e;
        send_image(im, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL empty_frame: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
        im[5] = 8'h80;
        send_image(im, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 0, 0, 0, 0, 0, 1, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL single_pixel: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
    endtask

    task automatic test_overflow();
        res_t r, e;
        // 9-pixel first line, the 9th set
        bif.per_frame_vsync = 1'b1;
        cyc(2);
        send_line(9, 16'h0102, 1'b0);
        send_line(8, 16'h0000, 1'b0);
        send_line(8, 16'h0004, 1'b0);
        repeat (3) send_line(8, 16'h0000, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 1, 2, 0, 2, 2, 1);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL line_overflow: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
        // 7 lines, the 7th holding a set pixel
        bif.per_frame_vsync = 1'b1;
        cyc(2);
        send_line(8, 16'h0001, 1'b0);
        repeat (5) send_line(8, 16'h0000, 1'b0);
        send_line(8, 16'h0008, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 0, 0, 0, 0, 0, 1, 1);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL frame_overflow: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
        begin
            img_t im = '{default: 8'h00};
            im[1] = 8'h24;
            im[4] = 8'h08;
            send_image(im, 1'b0);
        end
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 2, 5, 1, 4, 3, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL err_cleared: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
    endtask

    task automatic test_gaps();
        img_t im = '{default: 8'h00};
        res_t r, e;
        im[0] = 8'h01;
        im[5] = 8'h80;
        send_image(im, 1'b1);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 0, 7, 0, 5, 2, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL clken_gaps: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
    endtask

    task automatic test_reset_mid_frame();
        img_t im = '{default: 8'h00};
        res_t r, e;
        int   pulses = 0;
        bif.per_frame_vsync = 1'b1;
        cyc(2);
        send_line(8, 16'h0010, 1'b0);
        send_line(8, 16'h0000, 1'b0);
        sys_rst_n = 1'b0;
        cyc(1);
        r = got();
        tests_run++;
        if (r !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %s required all zero", fmt(r));
        end
        sys_rst_n = 1'b1;
        send_line(8, 16'h00FF, 1'b0);
        send_line(8, 16'h00FF, 1'b0);
        bif.per_frame_vsync = 1'b0;
        repeat (4) begin
            cyc(1);
            if (bif.box_valid) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_valid: got %0d valid pulses required 0", pulses);
        end
        im[1] = 8'h24;
        im[4] = 8'h08;
        send_image(im, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 2, 5, 1, 4, 3, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL reset_mid_next_frame: got %s required %s", fmt(r), fmt(e));
        end
        cyc(3);
    endtask

    task automatic test_back_to_back();
        img_t a = '{default: 8'h00};
        img_t b = '{default: 8'h00};
        res_t r, e;
        a[1] = 8'h24;
        a[4] = 8'h08;
        b[2] = 8'h40;
        b[3] = 8'h40;
        send_image(a, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 2, 5, 1, 4, 3, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL b2b_first: got %s required %s", fmt(r), fmt(e));
        end
        cyc(1);
        r = got(); e = ev(0, 1, 2, 5, 1, 4, 3, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL b2b_gap: got %s required %s", fmt(r), fmt(e));
        end
        send_image(b, 1'b0);
        bif.per_frame_vsync = 1'b0;
        cyc(1);
        r = got(); e = ev(1, 1, 6, 6, 2, 3, 2, 0);
        tests_run++;
        if (r !== e) begin
            tests_failed++;
            $display("FAIL b2b_second: got %s required %s", fmt(r), fmt(e));
        end
        cyc(1);
        tests_run++;
        if (bif.box_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_pulse_end: got valid=%0d required 0", bif.box_valid);
        end
        cyc(2);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time bound");
        $fatal(1);
    end

    initial begin
        bif.per_frame_vsync = 1'b0;
        bif.per_frame_href  = 1'b0;
        bif.per_frame_clken = 1'b0;
        bif.per_img_Bit     = 1'b0;
        sys_rst_n           = 1'b0;
        test_reset();
        test_basic();
        test_small_frames();
        test_overflow();
        test_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
